// File: rtl/dsp_alu_pkg.sv
// Shared constants for the DSP ALU: RV32I opcodes, operation codes,
// branch compare codes and the packed decoded-control word.
package dsp_alu_pkg;

  // Major opcodes (instruction bits [6:0])
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Operation select, ALUCtl[3:0]
  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_OR   = 4'd1;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_SRL  = 4'd3;
  localparam logic [3:0] ALU_SRA  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SUB  = 4'd6;
  localparam logic [3:0] ALU_SLT  = 4'd7;
  localparam logic [3:0] ALU_XOR  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  // Branch compare select, ALUCtl[6:4]
  localparam logic [2:0] BR_NONE = 3'd0;
  localparam logic [2:0] BR_BEQ  = 3'd1;
  localparam logic [2:0] BR_BNE  = 3'd2;
  localparam logic [2:0] BR_BLT  = 3'd3;
  localparam logic [2:0] BR_BGE  = 3'd4;
  localparam logic [2:0] BR_BLTU = 3'd5;
  localparam logic [2:0] BR_BGEU = 3'd6;

  // Packs so that {br, op} lines up with ALUCtl[6:0]
  typedef struct packed {
    logic [2:0] br;
    logic [3:0] op;
  } alu_ctl_t;

endpackage

// File: rtl/alu_ctl_decode.sv
// Combinational decode of {Opcode, FuncCode} into the ALU control word.
module alu_ctl_decode
  import dsp_alu_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [3:0] func_code,
  output alu_ctl_t   ctl
);

  logic [2:0] funct3;
  logic       alt;

  assign funct3 = func_code[2:0];
  assign alt    = func_code[3];

  // Decode: anything not ALU/branch falls back to ADD with no branch
  always_comb begin
    ctl.br = BR_NONE;
    ctl.op = ALU_ADD;
    case (opcode)
      OP_RTYPE, OP_ITYPE: begin
        case (funct3)
          // immediate form has no SUBI, so instr[30] only matters for R-type
          3'b000:  ctl.op = (opcode == OP_RTYPE && alt) ? ALU_SUB : ALU_ADD;
          3'b001:  ctl.op = ALU_SLL;
          3'b010:  ctl.op = ALU_SLT;
          3'b011:  ctl.op = ALU_SLTU;
          3'b100:  ctl.op = ALU_XOR;
          3'b101:  ctl.op = alt ? ALU_SRA : ALU_SRL;
          3'b110:  ctl.op = ALU_OR;
          default: ctl.op = ALU_AND;
        endcase
      end
      OP_BRANCH: begin
        ctl.op = ALU_SUB;
        case (funct3)
          3'b000:  ctl.br = BR_BEQ;
          3'b001:  ctl.br = BR_BNE;
          3'b100:  ctl.br = BR_BLT;
          3'b101:  ctl.br = BR_BGE;
          3'b110:  ctl.br = BR_BLTU;
          3'b111:  ctl.br = BR_BGEU;
          default: ctl.br = BR_NONE;
        endcase
      end
      // address generation and upper-immediate forms all use the adder
      OP_LOAD, OP_STORE, OP_JAL, OP_JALR, OP_AUIPC, OP_LUI: ;
      default: ;
    endcase
  end

endmodule

// File: rtl/dsp_alu.sv
// DSP ALU: decode, datapath, and one-cycle registered result/branch flag.
module dsp_alu
  import dsp_alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [6:0]        Opcode,
  input  logic [3:0]        FuncCode,
  output logic [DATA_W-1:0] ALUOut,
  output logic              Branch_Enable,
  output logic [6:0]        ALUCtl
);

  localparam int SH_W = $clog2(DATA_W);

  alu_ctl_t          ctl;
  logic [SH_W-1:0]   shamt;
  logic [DATA_W-1:0] result;
  logic              taken;
  logic              eq, lt_s, lt_u;

  alu_ctl_decode u_dec (
    .opcode    (Opcode),
    .func_code (FuncCode),
    .ctl       (ctl)
  );

  assign ALUCtl = ctl;
  assign shamt  = B[SH_W-1:0];
  assign eq     = (A == B);
  assign lt_s   = ($signed(A) < $signed(B));
  assign lt_u   = (A < B);

  // Result mux; add/sub wrap naturally at DATA_W bits
  always_comb begin
    result = '0;
    case (ctl.op)
      ALU_AND:  result = A & B;
      ALU_OR:   result = A | B;
      ALU_ADD:  result = A + B;
      ALU_SRL:  result = A >> shamt;
      ALU_SRA:  result = $unsigned($signed(A) >>> shamt);
      ALU_SLL:  result = A << shamt;
      ALU_SUB:  result = A - B;
      ALU_SLT:  result = {{(DATA_W-1){1'b0}}, lt_s};
      ALU_XOR:  result = A ^ B;
      ALU_SLTU: result = {{(DATA_W-1){1'b0}}, lt_u};
      default:  result = '0;
    endcase
  end

  // Branch condition straight from the operands, not from the subtractor
  always_comb begin
    taken = 1'b0;
    case (ctl.br)
      BR_BEQ:  taken = eq;
      BR_BNE:  taken = !eq;
      BR_BLT:  taken = lt_s;
      BR_BGE:  taken = !lt_s;
      BR_BLTU: taken = lt_u;
      BR_BGEU: taken = !lt_u;
      default: taken = 1'b0;
    endcase
  end

  // Output registers; reset clears them immediately and drops in-flight work
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ALUOut        <= '0;
      Branch_Enable <= 1'b0;
    end else begin
      ALUOut        <= result;
      Branch_Enable <= taken;
    end
  end

endmodule

// File: tb/tb_dsp_alu.sv
// Self-checking bench for dsp_alu: directed literal cases plus random
// stimulus compared every cycle against an instruction-level model.
module tb_dsp_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] A, B;
  logic [6:0]  Opcode;
  logic [3:0]  FuncCode;
  logic [31:0] ALUOut;
  logic        Branch_Enable;
  logic [6:0]  ALUCtl;

  int checks = 0;
  int fails  = 0;
  bit mon_en = 1'b0;

  logic [31:0] exp_res;
  logic        exp_br;
  logic        exp_valid;

  dsp_alu #(.DATA_W(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .A             (A),
    .B             (B),
    .Opcode        (Opcode),
    .FuncCode      (FuncCode),
    .ALUOut        (ALUOut),
    .Branch_Enable (Branch_Enable),
    .ALUCtl        (ALUCtl)
  );

  always #5 clk = ~clk;

  // Instruction-level reference: what an RV32I ALU must produce
  function automatic void model(input logic [6:0] op, input logic [3:0] fc,
                                input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] res, output logic br,
                                output logic [6:0] ctl);
    longint sa, sb, ua, ub;
    int     sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    sh = int'(b[4:0]);
    res = a + b;
    br  = 1'b0;
    ctl = 7'd2;
    if (op == 7'h33 || op == 7'h13) begin
      case (fc[2:0])
        3'd0: if (op == 7'h33 && fc[3]) begin res = a - b; ctl = 7'd6; end
        3'd1: begin res = a << sh; ctl = 7'd5; end
        3'd2: begin res = (sa < sb) ? 32'd1 : 32'd0; ctl = 7'd7; end
        3'd3: begin res = (ua < ub) ? 32'd1 : 32'd0; ctl = 7'd9; end
        3'd4: begin res = a ^ b; ctl = 7'd8; end
        3'd5: begin
          res = a >> sh;
          ctl = 7'd3;
          if (fc[3]) begin
            if (a[31]) res = res | ~(32'hFFFF_FFFF >> sh);
            ctl = 7'd4;
          end
        end
        3'd6: begin res = a | b; ctl = 7'd1; end
        default: begin res = a & b; ctl = 7'd0; end
      endcase
    end else if (op == 7'h63) begin
      res = a - b;
      case (fc[2:0])
        3'd0: begin br = (a == b);  ctl = 7'h16; end
        3'd1: begin br = (a != b);  ctl = 7'h26; end
        3'd4: begin br = (sa < sb); ctl = 7'h36; end
        3'd5: begin br = (sa >= sb); ctl = 7'h46; end
        3'd6: begin br = (ua < ub); ctl = 7'h56; end
        3'd7: begin br = (ua >= ub); ctl = 7'h66; end
        default: ctl = 7'h06;
      endcase
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected registered outputs, tracking reset the way the contract demands
  always @(posedge clk or negedge rst_n) begin
    logic [31:0] r;
    logic        bb;
    logic [6:0]  c;
    if (!rst_n) begin
      exp_valid <= 1'b0;
    end else begin
      model(Opcode, FuncCode, A, B, r, bb, c);
      exp_res   <= r;
      exp_br    <= bb;
      exp_valid <= 1'b1;
    end
  end

  // Per-cycle comparison on the falling edge
  always @(negedge clk) begin
    logic [31:0] r;
    logic        bb;
    logic [6:0]  c;
    if (mon_en) begin
      model(Opcode, FuncCode, A, B, r, bb, c);
      chk("mon_aluctl", {25'd0, ALUCtl}, {25'd0, c});
      if (!rst_n || !exp_valid) begin
        chk("mon_rst_out", ALUOut, 32'd0);
        chk("mon_rst_br", {31'd0, Branch_Enable}, 32'd0);
      end else begin
        chk("mon_out", ALUOut, exp_res);
        chk("mon_br", {31'd0, Branch_Enable}, {31'd0, exp_br});
      end
    end
  end

  // Apply one operation, wait one edge, check result literally
  task automatic op_chk(input string name, input logic [6:0] op, input logic [3:0] fc,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    Opcode = op; FuncCode = fc; A = a; B = b;
    @(posedge clk); #1;
    chk(name, ALUOut, exp);
  endtask

  task automatic br_chk(input string name, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b, input logic exp);
    Opcode = 7'h63; FuncCode = {1'b0, f3}; A = a; B = b;
    @(posedge clk); #1;
    chk(name, {31'd0, Branch_Enable}, {31'd0, exp});
  endtask

  initial begin
    logic [6:0]  ops [10];
    logic [31:0] corner [6];
    ops = '{7'h33, 7'h13, 7'h63, 7'h03, 7'h23, 7'h6f, 7'h67, 7'h17, 7'h37, 7'h00};
    corner = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1, 32'h1F};

    rst_n = 1'b0; A = '0; B = '0; Opcode = 7'h33; FuncCode = 4'h0;
    #1;
    chk("reset_out", ALUOut, 32'd0);
    chk("reset_br", {31'd0, Branch_Enable}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    mon_en = 1'b1;

    op_chk("and",        7'h33, 4'b0111, 32'h0F, 32'h55, 32'h05);
    op_chk("add_10111",  7'h33, 4'b0000, 32'd10000, 32'd111, 32'd10111);
    op_chk("add_10001",  7'h33, 4'b0000, 32'd1, 32'h10000, 32'h10001);
    op_chk("add_c00",    7'h33, 4'b0000, 32'hB00, 32'h100, 32'hC00);
    op_chk("add_1fffe",  7'h33, 4'b0000, 32'hFFFF, 32'hFFFF, 32'h1FFFE);
    op_chk("add_zero",   7'h33, 4'b0000, 32'd0, 32'd0, 32'd0);
    op_chk("add_wrap",   7'h33, 4'b0000, 32'hFFFF_FFFF, 32'd1, 32'd0);
    op_chk("sub_9889",   7'h33, 4'b1000, 32'd10000, 32'd111, 32'd9889);
    op_chk("sub_wrap",   7'h33, 4'b1000, 32'd0, 32'd1, 32'hFFFF_FFFF);
    op_chk("addi_alt",   7'h13, 4'b1000, 32'd10000, 32'd111, 32'd10111);
    op_chk("slt",        7'h33, 4'b0010, 32'd0, 32'd2, 32'd1);
    op_chk("slt_neg",    7'h33, 4'b0010, 32'hFFFF_FFFF, 32'd0, 32'd1);
    op_chk("sltu_neg",   7'h33, 4'b0011, 32'hFFFF_FFFF, 32'd0, 32'd0);
    op_chk("srl",        7'h33, 4'b0101, 32'd16, 32'd2, 32'd4);
    op_chk("sra",        7'h33, 4'b1101, 32'd8, 32'd1, 32'd4);
    op_chk("sra_neg",    7'h33, 4'b1101, 32'h8000_0000, 32'd1, 32'hC000_0000);
    op_chk("sll",        7'h33, 4'b0001, 32'd2, 32'd2, 32'd8);
    op_chk("sll_shamt5", 7'h33, 4'b0001, 32'd1, 32'h0000_0021, 32'd2);
    op_chk("xor",        7'h33, 4'b0100, 32'h55, 32'hFF, 32'hAA);
    op_chk("lui_add",    7'h37, 4'b1101, 32'd3, 32'd4, 32'd7);
    br_chk("beq",  3'd0, 32'd5, 32'd5, 1'b1);
    br_chk("bne",  3'd1, 32'd5, 32'd5, 1'b0);
    br_chk("bltu", 3'd6, 32'd1, 32'hFFFF_FFFF, 1'b1);
    br_chk("blt",  3'd4, 32'd1, 32'hFFFF_FFFF, 1'b0);
    br_chk("bge",  3'd5, 32'h8000_0000, 32'd0, 1'b0);
    br_chk("bnone",3'd2, 32'd5, 32'd5, 1'b0);

    // Mid-stream reset with both outputs non-zero
    br_chk("beq_pre", 3'd0, 32'd7, 32'd7, 1'b1);
    op_chk("add_pre", 7'h33, 4'b0000, 32'd5, 32'd5, 32'd10);
    Opcode = 7'h63; FuncCode = 4'b0000; A = 32'd9; B = 32'd9;
    @(posedge clk); #1;
    chk("pre_rst_br", {31'd0, Branch_Enable}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out", ALUOut, 32'd0);
    chk("async_rst_br", {31'd0, Branch_Enable}, 32'd0);
    Opcode = 7'h33; FuncCode = 4'b0000; A = 32'd1; B = 32'd2;
    @(posedge clk); #1;
    chk("hold_rst_out", ALUOut, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("first_capture", ALUOut, 32'd3);

    // Random traffic with occasional reset pulses
    for (int i = 0; i < 3000; i++) begin
      Opcode   = ops[$urandom_range(9)];
      if ($urandom_range(15) == 0) Opcode = 7'($urandom);
      FuncCode = 4'($urandom);
      A = ($urandom_range(3) == 0) ? corner[$urandom_range(5)] : $urandom;
      B = ($urandom_range(3) == 0) ? corner[$urandom_range(5)] : $urandom;
      if ($urandom_range(7) == 0) B = A;
      if ($urandom_range(99) == 0) begin
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
      @(posedge clk); #1;
    end

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
